// File: rtl/rx_ctrl.sv
// Receive-path sequencer for a UART-style bit timer and stop-bit checker.
// Outputs are Moore decodes, registered alongside the state so no input reaches an output combinationally.
module rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_bit_detected,
    input  logic       packet_done,
    input  logic       framing_error,
    input  logic       err_clr,
    output logic       timer_clear,
    output logic       enable_timer,
    output logic       sbc_clear,
    output logic       sbc_enable,
    output logic       load_buffer,
    output logic       timeout_err,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SAMPLE,
        STOP,
        CHECK,
        LOAD,
        ABORT
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  err_count_q, err_count_d;

    logic timer_clear_q,  timer_clear_d;
    logic enable_timer_q, enable_timer_d;
    logic sbc_clear_q,    sbc_clear_d;
    logic sbc_enable_q,   sbc_enable_d;
    logic load_buffer_q,  load_buffer_d;
    logic timeout_err_q,  timeout_err_d;
    logic busy_q,         busy_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (start_bit_detected) state_d = START;
            end
            START: begin
                wait_cnt_d = 16'd0;
                state_d    = SAMPLE;
            end
            SAMPLE: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                // A completed packet outranks a coincident timeout.
                if (packet_done)                   state_d = STOP;
                else if (wait_cnt_q == WAIT_LAST)  state_d = ABORT;
            end
            STOP: state_d = CHECK;
            CHECK: begin
                if (framing_error) begin
                    state_d     = IDLE;
                    err_count_d = sat_inc(err_count_q);
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (err_clr) err_count_d = 8'd0;

        // Decode from the next state so the registered outputs line up with state_q.
        timer_clear_d  = (state_d == START);
        sbc_clear_d    = (state_d == START);
        enable_timer_d = (state_d == SAMPLE);
        sbc_enable_d   = (state_d == STOP);
        load_buffer_d  = (state_d == LOAD);
        timeout_err_d  = (state_d == ABORT);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 16'd0;
            err_count_q    <= 8'd0;
            timer_clear_q  <= 1'b0;
            enable_timer_q <= 1'b0;
            sbc_clear_q    <= 1'b0;
            sbc_enable_q   <= 1'b0;
            load_buffer_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            err_count_q    <= err_count_d;
            timer_clear_q  <= timer_clear_d;
            enable_timer_q <= enable_timer_d;
            sbc_clear_q    <= sbc_clear_d;
            sbc_enable_q   <= sbc_enable_d;
            load_buffer_q  <= load_buffer_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign timer_clear  = timer_clear_q;
    assign enable_timer = enable_timer_q;
    assign sbc_clear    = sbc_clear_q;
    assign sbc_enable   = sbc_enable_q;
    assign load_buffer  = load_buffer_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Bench for rx_ctrl: directed vector table, multi-cycle frame sequences and
// randomized traffic checked against a frame-timeline reference model.
module tb_rx_ctrl;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_bit_detected, packet_done, framing_error, err_clr;
    logic       timer_clear, enable_timer, sbc_clear, sbc_enable;
    logic       load_buffer, timeout_err, busy;
    logic [7:0] err_count;
    logic [14:0] dut_out;

    int nvec  = 0;
    int nfail = 0;

    rx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .packet_done        (packet_done),
        .framing_error      (framing_error),
        .err_clr            (err_clr),
        .timer_clear        (timer_clear),
        .enable_timer       (enable_timer),
        .sbc_clear          (sbc_clear),
        .sbc_enable         (sbc_enable),
        .load_buffer        (load_buffer),
        .timeout_err        (timeout_err),
        .busy               (busy),
        .err_count          (err_count)
    );

    always #5 clk = ~clk;

    // Packed as {timer_clear, enable_timer, sbc_clear, sbc_enable, load_buffer, timeout_err, busy, err_count}
    assign dut_out = {timer_clear, enable_timer, sbc_clear, sbc_enable,
                      load_buffer, timeout_err, busy, err_count};

    localparam logic [6:0] F_IDLE   = 7'b0000000;
    localparam logic [6:0] F_START  = 7'b1010001;
    localparam logic [6:0] F_SAMPLE = 7'b0100001;
    localparam logic [6:0] F_STOP   = 7'b0001001;
    localparam logic [6:0] F_CHECK  = 7'b0000001;
    localparam logic [6:0] F_LOAD   = 7'b0000101;

    // Reference model: a frame is a timeline measured from its start edge.
    // t=0 start cycle, t=1.. sampling cycles; once packet_done is seen at
    // sample cycle pd, t=pd+1 stop strobe, pd+2 check, pd+3 load.
    bit m_act, m_abort;
    int m_t, m_pd, m_err;

    function automatic logic [14:0] model_out();
        logic tc, en, sc, se, ld, to;
        {tc, en, sc, se, ld, to} = 6'b0;
        if (m_act) begin
            if (m_abort)            to = 1'b1;
            else if (m_t == 0)      begin tc = 1'b1; sc = 1'b1; end
            else if (m_pd < 0)      en = 1'b1;
            else if (m_t == m_pd+1) se = 1'b1;
            else if (m_t == m_pd+3) ld = 1'b1;
        end
        return {tc, en, sc, se, ld, to, m_act, 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_act = 0; m_abort = 0; m_t = 0; m_pd = -1; m_err = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit f, input bit c);
        int nerr;
        nerr = m_err;
        if (c) nerr = 0;
        else if (m_act && !m_abort && m_pd >= 0 && m_t == m_pd+2 && f && m_err < 255)
            nerr = m_err + 1;
        if (!m_act) begin
            if (s) begin m_act = 1; m_t = 0; m_pd = -1; m_abort = 0; end
        end else if (m_abort) begin
            m_act = 0;
        end else if (m_t == 0) begin
            m_t = 1;
        end else if (m_pd < 0) begin
            if (p)             begin m_pd = m_t; m_t++; end
            else if (m_t == TO) m_abort = 1;
            else               m_t++;
        end else if (m_t == m_pd+1) begin
            m_t++;
        end else if (m_t == m_pd+2) begin
            if (f) m_act = 0; else m_t++;
        end else begin
            m_act = 0;
        end
        m_err = nerr;
    endtask

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s at %0t: got flags=%b err=%0d, want flags=%b err=%0d",
                     name, $time, got[14:8], got[7:0], want[14:8], want[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    // One clock: drive inputs away from the edge, advance model, sample #1 after.
    task automatic tick(input bit s, input bit p, input bit f, input bit c);
        start_bit_detected = s; packet_done = p; framing_error = f; err_clr = c;
        @(posedge clk);
        model_step(s, p, f, c);
        #1;
        check("model", dut_out, model_out());
    endtask

    task automatic async_reset();
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset", dut_out, 15'd0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    int c_tc, c_en, c_sen, c_ld, c_to;

    // pd_cycle: sampling cycle during which packet_done is high (0 = never).
    task automatic frame(input int pd_cycle, input bit fe, input bit clr, input int total);
        c_tc = 0; c_en = 0; c_sen = 0; c_ld = 0; c_to = 0;
        for (int i = 0; i <= total; i++) begin
            tick(i == 0,
                 (pd_cycle != 0) && (i == pd_cycle + 1),
                 fe,
                 clr && (i == pd_cycle + 3));
            c_tc  += int'(timer_clear);
            c_en  += int'(enable_timer);
            c_sen += int'(sbc_enable);
            c_ld  += int'(load_buffer);
            c_to  += int'(timeout_err);
        end
    endtask

    typedef struct packed {
        logic       s, p, f, c;
        logic [6:0] fl;
        logic [7:0] er;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, F_START,  8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_SAMPLE, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, F_SAMPLE, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, F_STOP,   8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, F_CHECK,  8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, F_IDLE,   8'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, F_START,  8'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, F_SAMPLE, 8'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, F_STOP,   8'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, F_CHECK,  8'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, F_LOAD,   8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, F_IDLE,   8'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, F_START,  8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, F_SAMPLE, 8'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, F_STOP,   8'd0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, F_CHECK,  8'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, F_IDLE,   8'd0};

        model_reset();
        n_rst = 1'b0;
        start_bit_detected = 1'b1; packet_done = 1'b0; framing_error = 1'b0; err_clr = 1'b0;
        #1;
        check("por_async", dut_out, 15'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("por_hold", dut_out, 15'd0);
        end
        @(negedge clk);
        start_bit_detected = 1'b0;
        n_rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].c);
            check($sformatf("table_row%0d", i), dut_out, {tbl[i].fl, tbl[i].er});
        end

        // Good frame: packet_done arrives after 10 full sampling cycles.
        frame(11, 1'b0, 1'b0, 17);
        check_int("good_timer_clear", c_tc, 1);
        check_int("good_enable_timer", c_en, 11);
        check_int("good_sbc_enable", c_sen, 1);
        check_int("good_load", c_ld, 1);
        check("good_end", dut_out, {F_IDLE, 8'd0});

        frame(0, 1'b0, 1'b0, TO + 5);
        check_int("timeout_enable_timer", c_en, TO);
        check_int("timeout_pulse", c_to, 1);
        check_int("timeout_no_load", c_ld, 0);
        check("timeout_end", dut_out, {F_IDLE, 8'd0});

        frame(TO, 1'b0, 1'b0, TO + 6);
        check_int("edge_pd_enable_timer", c_en, TO);
        check_int("edge_pd_no_timeout", c_to, 0);
        check_int("edge_pd_sbc_enable", c_sen, 1);
        check_int("edge_pd_load", c_ld, 1);

        frame(1, 1'b1, 1'b0, 6);
        check_int("fe_no_load", c_ld, 0);
        check("fe_count1", dut_out, {F_IDLE, 8'd1});
        for (int i = 0; i < 255; i++) frame(1, 1'b1, 1'b0, 6);
        check("fe_saturate", dut_out, {F_IDLE, 8'd255});
        tick(0, 0, 0, 1);
        check("err_clear", dut_out, {F_IDLE, 8'd0});

        for (int i = 0; i < 5; i++) frame(1, 1'b1, 1'b0, 6);
        check("fe_count5", dut_out, {F_IDLE, 8'd5});
        frame(1, 1'b1, 1'b1, 6);
        check("clr_beats_inc", dut_out, {F_IDLE, 8'd0});

        // Reset while sampling with a non-zero error count.
        frame(1, 1'b1, 1'b0, 6);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        async_reset();
        c_ld = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, (i % 3) == 0, 0, 0);
            c_ld += int'(load_buffer);
        end
        check_int("rst_no_load", c_ld, 0);
        check("rst_idle", dut_out, {F_IDLE, 8'd0});

        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 4) == 0, ($urandom % 64) == 0,
                 ($urandom % 2) == 1, ($urandom % 32) == 0);
            if (($urandom % 400) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
